// File: rtl/usb_fs_host_tx.sv
// Full-speed USB host packet transmitter: SYNC, NRZI with bit stuffing, and EOP on D+/D-.
// Bytes are fetched LSB first. A new byte is accepted in IDLE or at the last cycle of each byte's bit 7.
module usb_fs_host_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int STUFF_LIMIT  = 6
) (
  input  logic       clk48,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       usb_p_tx,
  output logic       usb_n_tx,
  output logic       usb_oe,
  output logic       busy,
  output logic       underflow,
  output logic [1:0] dbg_state
);
  // Handshake: a byte moves across the interface on any cycle where tx_valid and tx_ready are both high.
  // tx_ready is a combinational pulse, and it is offered only at the two points where a byte can be accepted.
  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_EOP} state_t;

  localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PHASE_ONE  = PW'(1);
  localparam logic [2:0]    STUFF_MAX  = 3'(STUFF_LIMIT);

  state_t        r_state, w_state;
  logic [PW-1:0] r_phase, w_phase;
  logic [3:0]    r_idx, w_idx;   // next bit to send; 8 means the byte is exhausted
  logic [7:0]    r_shift, w_shift;
  logic          r_last, w_last;
  logic [2:0]    r_ones, w_ones;
  logic          r_p, w_p, r_n, w_n, r_oe, w_oe;
  logic          w_wrap, w_accept, w_underflow, w_emit, w_eop, w_bit;
  logic [7:0]    w_byte;
  logic [3:0]    w_cur;

  always_comb begin
    w_state     = r_state;
    w_phase     = r_phase;
    w_idx       = r_idx;
    w_shift     = r_shift;
    w_last      = r_last;
    w_ones      = r_ones;
    w_p         = r_p;
    w_n         = r_n;
    w_oe        = r_oe;
    w_accept    = 1'b0;
    w_underflow = 1'b0;
    w_emit      = 1'b0;
    w_eop       = 1'b0;
    w_bit       = 1'b0;
    w_byte      = r_shift;
    w_cur       = r_idx;
    w_wrap      = (r_phase == PHASE_LAST);
    if (r_state != S_IDLE) w_phase = w_wrap ? '0 : r_phase + PHASE_ONE;

    case (r_state)
      S_IDLE: begin
        if (tx_valid) begin
          w_accept = 1'b1;
          w_shift  = tx_data;
          w_last   = tx_last;
          w_state  = S_SYNC;
          w_phase  = '0;
          w_idx    = 4'd1;
          w_p      = 1'b0;
          w_n      = 1'b1;
          w_oe     = 1'b1;
        end
      end
      S_SYNC: begin
        if (w_wrap) begin
          if (r_idx == 4'd8) begin
            w_state = S_DATA;
            w_emit  = 1'b1;
            w_cur   = 4'd0;
          end else begin
            // SYNC is seven zeros then a one; that final one seeds the stuff count.
            if (r_idx != 4'd7) {w_p, w_n} = {r_n, r_p};
            else               w_ones = 3'd1;
            w_idx = r_idx + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (w_wrap) begin
          if (r_idx == 4'd8 && !r_last && !tx_valid) begin
            w_underflow = 1'b1;
            w_eop       = 1'b1;
          end else begin
            if (r_idx == 4'd8 && !r_last) begin
              w_accept = 1'b1;
              w_shift  = tx_data;
              w_last   = tx_last;
              w_byte   = tx_data;
              w_cur    = 4'd0;
            end
            if (r_ones == STUFF_MAX) begin
              {w_p, w_n} = {r_n, r_p};
              w_ones     = 3'd0;
              w_idx      = w_cur;
            end else if (w_cur == 4'd8) begin
              w_eop = 1'b1;
            end else begin
              w_emit = 1'b1;
            end
          end
        end
      end
      S_EOP: begin
        // r_idx counts EOP bit times: SE0, SE0, then J.
        if (w_wrap) begin
          if (r_idx == 4'd0) begin
            w_idx = 4'd1;
          end else if (r_idx == 4'd1) begin
            w_idx = 4'd2;
            w_p   = 1'b1;
            w_n   = 1'b0;
          end else begin
            w_state = S_IDLE;
            w_idx   = 4'd0;
            w_oe    = 1'b0;
          end
        end
      end
    endcase

    if (w_eop) begin
      w_state = S_EOP;
      w_idx   = 4'd0;
      w_p     = 1'b0;
      w_n     = 1'b0;
    end
    if (w_emit) begin
      w_bit = w_byte[w_cur[2:0]];
      w_idx = w_cur + 4'd1;
      if (w_bit) begin
        w_ones = r_ones + 3'd1;
      end else begin
        w_ones     = 3'd0;
        {w_p, w_n} = {r_n, r_p};
      end
    end
  end

  always_ff @(posedge clk48) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_phase <= '0;
      r_idx   <= 4'd0;
      r_shift <= 8'd0;
      r_last  <= 1'b0;
      r_ones  <= 3'd0;
      r_p     <= 1'b1;
      r_n     <= 1'b0;
      r_oe    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_phase <= w_phase;
      r_idx   <= w_idx;
      r_shift <= w_shift;
      r_last  <= w_last;
      r_ones  <= w_ones;
      r_p     <= w_p;
      r_n     <= w_n;
      r_oe    <= w_oe;
    end
  end

  assign tx_ready  = w_accept & ~rst;
  assign underflow = w_underflow & ~rst;
  assign usb_p_tx  = r_p;
  assign usb_n_tx  = r_n;
  assign usb_oe    = r_oe;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;
endmodule

// File: tb/tb_usb_fs_host_tx.sv
// Bench for usb_fs_host_tx: a line-symbol reference model fills exp_q, and a negedge monitor pops and compares it while oe is high.
module tb_usb_fs_host_tx;
  localparam int CLKS = 4;
  localparam logic [1:0] SYM_J = 2'b10, SYM_K = 2'b01, SYM_SE0 = 2'b00;

  logic       clk48 = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid, tx_last;
  logic       tx_ready, usb_p_tx, usb_n_tx, usb_oe, busy, underflow;
  logic [1:0] dbg_state;

  usb_fs_host_tx #(.CLKS_PER_BIT(CLKS), .STUFF_LIMIT(6)) dut (
    .clk48(clk48), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .usb_p_tx(usb_p_tx), .usb_n_tx(usb_n_tx), .usb_oe(usb_oe),
    .busy(busy), .underflow(underflow), .dbg_state(dbg_state)
  );

  always #10 clk48 = ~clk48;

  logic [1:0] exp_q[$];
  logic [1:0] sb_exp;
  logic [7:0] pkt[0:3];
  int tests_run = 0, tests_failed = 0;
  bit sb_en = 1'b1;
  int oe_idx = 0, last_oe_len = 0, oe_falls = 0, oe_rises = 0;
  int idle_run = 0, last_gap = 0, rdy_cnt = 0, ufl_cnt = 0, ufl_idx = -1;
  logic oe_prev = 1'b0;

  // Monitor and scoreboard
  always @(negedge clk48) begin
    #2;
    if (tx_ready === 1'b1) rdy_cnt++;
    if (underflow === 1'b1) begin ufl_cnt++; ufl_idx = oe_idx; end
    if (usb_oe === 1'b1) begin
      if (!oe_prev) begin oe_idx = 0; oe_rises++; last_gap = idle_run; end
      if (sb_en) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_extra: line=%b at oe cycle %0d, required nothing", {usb_p_tx, usb_n_tx}, oe_idx);
        end else begin
          sb_exp = exp_q.pop_front();
          if ({usb_p_tx, usb_n_tx} !== sb_exp) begin
            tests_failed++;
            $display("FAIL line: oe cycle %0d got %b required %b", oe_idx, {usb_p_tx, usb_n_tx}, sb_exp);
          end
        end
      end
      oe_idx++;
    end else begin
      if (oe_prev) begin last_oe_len = oe_idx; oe_falls++; idle_run = 0; end
      idle_run++;
    end
    oe_prev = usb_oe;
  end

  task automatic push_sym(input logic [1:0] s);
    repeat (CLKS) exp_q.push_back(s);
  endtask

  task automatic model_packet(input int n);
    logic [1:0] lvl;
    int ones;
    logic b;
    lvl = SYM_J;
    for (int i = 0; i < 8; i++) begin
      if (i != 7) lvl = ~lvl;
      push_sym(lvl);
    end
    ones = 1;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 8; i++) begin
        b = pkt[k][i];
        if (b) ones++;
        else begin ones = 0; lvl = ~lvl; end
        push_sym(lvl);
        if (ones == 6) begin ones = 0; lvl = ~lvl; push_sym(lvl); end
      end
    end
    push_sym(SYM_SE0);
    push_sym(SYM_SE0);
    push_sym(SYM_J);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    @(negedge clk48);
    tx_data = b; tx_last = last; tx_valid = 1'b1;
    n = 0;
    #1;
    while (tx_ready !== 1'b1 && n < 400) begin @(negedge clk48); #1; n++; end
    tests_run++;
    if (tx_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL accept: byte %h not accepted within %0d cycles", b, n);
    end else begin
      @(posedge clk48); #1;
    end
  endtask

  task automatic wait_falls(input int target);
    int n;
    n = 0;
    while (oe_falls < target && n < 2000) begin @(negedge clk48); #3; n++; end
    tests_run++;
    if (oe_falls < target) begin
      tests_failed++;
      $display("FAIL packet_done: oe falls %0d required %0d", oe_falls, target);
    end
  endtask

  task automatic check_sb_empty(input string name);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_sb_left: %0d symbols not seen, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; tx_valid = 1'b1; tx_data = 8'hD2; tx_last = 1'b1;
    repeat (3) begin
      @(negedge clk48); #1;
      tests_run++;
      if (tx_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b required 0", tx_ready); end
    end
    tests_run++;
    if ({usb_p_tx, usb_n_tx} !== SYM_J) begin tests_failed++; $display("FAIL reset_line: got %b required 10", {usb_p_tx, usb_n_tx}); end
    tests_run++;
    if (usb_oe !== 1'b0 || busy !== 1'b0 || underflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctl: oe=%b busy=%b underflow=%b required 0 0 0", usb_oe, busy, underflow);
    end
    tests_run++;
    if (dbg_state !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d required 0", dbg_state); end
    tx_valid = 1'b0;
    @(negedge clk48); rst = 1'b0;
    repeat (4) @(negedge clk48);
    #3;
    tests_run++;
    if (usb_oe !== 1'b0 || oe_rises != 0) begin
      tests_failed++;
      $display("FAIL reset_no_accept: oe=%b rises=%0d required 0 0", usb_oe, oe_rises);
    end
  endtask

  task automatic test_ack;
    int f0;
    f0 = oe_falls; rdy_cnt = 0;
    pkt[0] = 8'hD2; model_packet(1);
    send_byte(8'hD2, 1'b1); tx_valid = 1'b0;
    wait_falls(f0 + 1);
    check_sb_empty("ack");
    tests_run++;
    if (last_oe_len != 76) begin tests_failed++; $display("FAIL ack_oe_len: got %0d required 76", last_oe_len); end
    tests_run++;
    if (rdy_cnt != 1) begin tests_failed++; $display("FAIL ack_ready: got %0d pulses required 1", rdy_cnt); end
  endtask

  task automatic test_stuffing;
    int f0, r0;
    f0 = oe_falls; r0 = oe_rises; rdy_cnt = 0;
    pkt[0] = 8'hFF; pkt[1] = 8'hFF; model_packet(2);
    send_byte(8'hFF, 1'b0); send_byte(8'hFF, 1'b1); tx_valid = 1'b0;
    wait_falls(f0 + 1);
    check_sb_empty("stuff");
    tests_run++;
    if (last_oe_len != 116) begin tests_failed++; $display("FAIL stuff_oe_len: got %0d required 116", last_oe_len); end
    tests_run++;
    if (rdy_cnt != 2 || oe_rises != r0 + 1) begin
      tests_failed++;
      $display("FAIL stuff_ready: pulses %0d oe rises %0d required 2 1", rdy_cnt, oe_rises - r0);
    end
  endtask

  task automatic test_stuff_at_end;
    int f0;
    f0 = oe_falls;
    pkt[0] = 8'hFC; model_packet(1);
    send_byte(8'hFC, 1'b1); tx_valid = 1'b0;
    wait_falls(f0 + 1);
    check_sb_empty("stuff_end");
    tests_run++;
    if (last_oe_len != 80) begin tests_failed++; $display("FAIL stuff_end_oe_len: got %0d required 80", last_oe_len); end
  endtask

  task automatic test_underflow;
    int f0;
    f0 = oe_falls; ufl_cnt = 0; ufl_idx = -1;
    pkt[0] = 8'h69; model_packet(1);
    send_byte(8'h69, 1'b0); tx_valid = 1'b0;
    wait_falls(f0 + 1);
    check_sb_empty("underflow");
    tests_run++;
    if (ufl_cnt != 1) begin tests_failed++; $display("FAIL underflow_count: got %0d required 1", ufl_cnt); end
    tests_run++;
    if (ufl_idx != 63) begin tests_failed++; $display("FAIL underflow_point: oe cycle %0d required 63", ufl_idx); end
    tests_run++;
    if (last_oe_len != 76 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL underflow_eop: oe len %0d busy %b required 76 0", last_oe_len, busy);
    end
  endtask

  task automatic test_reset_mid;
    int n, f0;
    sb_en = 1'b0;
    @(negedge clk48);
    tx_data = 8'hA5; tx_last = 1'b0; tx_valid = 1'b1;
    n = 0;
    do begin @(negedge clk48); #3; n++; end while (!(usb_oe === 1'b1 && oe_idx >= 80) && n < 400);
    tests_run++;
    if (n >= 400) begin tests_failed++; $display("FAIL reset_mid_reach: oe_idx %0d required >= 80", oe_idx); end
    @(negedge clk48); rst = 1'b1;
    @(negedge clk48); #1;
    tests_run++;
    if (tx_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_mid_ready: got %b required 0", tx_ready); end
    rst = 1'b0; tx_valid = 1'b0;
    tests_run++;
    if ({usb_p_tx, usb_n_tx, usb_oe, busy} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL reset_mid_out: p n oe busy = %b required 1000", {usb_p_tx, usb_n_tx, usb_oe, busy});
    end
    #3;
    exp_q.delete();
    sb_en = 1'b1;
    f0 = oe_falls;
    pkt[0] = 8'hC3; model_packet(1);
    send_byte(8'hC3, 1'b1); tx_valid = 1'b0;
    wait_falls(f0 + 1);
    check_sb_empty("reset_mid_next");
    tests_run++;
    if (last_oe_len != 76) begin tests_failed++; $display("FAIL reset_mid_oe_len: got %0d required 76", last_oe_len); end
  endtask

  task automatic test_back_to_back;
    int f0;
    f0 = oe_falls; rdy_cnt = 0;
    pkt[0] = 8'hD2; model_packet(1);
    pkt[0] = 8'h5A; model_packet(1);
    send_byte(8'hD2, 1'b1); send_byte(8'h5A, 1'b1); tx_valid = 1'b0;
    wait_falls(f0 + 2);
    check_sb_empty("b2b");
    tests_run++;
    if (last_gap < 1) begin tests_failed++; $display("FAIL b2b_gap: idle cycles %0d required >= 1", last_gap); end
    tests_run++;
    if (rdy_cnt != 2) begin tests_failed++; $display("FAIL b2b_ready: got %0d pulses required 2", rdy_cnt); end
  endtask

  task automatic test_random;
    int n, f0;
    for (int p = 0; p < 4; p++) begin
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) pkt[k] = 8'($urandom_range(0, 255));
      f0 = oe_falls; rdy_cnt = 0;
      model_packet(n);
      for (int k = 0; k < n; k++) send_byte(pkt[k], (k == n - 1));
      tx_valid = 1'b0;
      wait_falls(f0 + 1);
      check_sb_empty("random");
      tests_run++;
      if (rdy_cnt != n) begin tests_failed++; $display("FAIL random_ready: got %0d pulses required %0d", rdy_cnt, n); end
    end
  endtask

  initial begin
    test_reset();
    test_ack();
    test_stuffing();
    test_stuff_at_end();
    test_underflow();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
